// File: rtl/jsv_pkg.sv
// Shared types and constants for the fractal pixel transmitter slice.
package jsv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } pix_state_t;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;

endpackage

// File: rtl/fractal_pixel_tx_raster_counter.sv
// Raster-order x/y counter with synchronous clear, advance enable and a
// combinational flag marking the last coordinate of the frame.
module raster_counter
  import jsv_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last_c
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

  logic [COORD_W-1:0] x_d;
  logic [COORD_W-1:0] y_d;

  assign last_c = (x == X_MAX) && (y == Y_MAX);

  // Next coordinate: clear wins over advance; x wraps into a y step.
  always_comb begin
    x_d = x;
    y_d = y;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x == X_MAX) begin
        x_d = '0;
        y_d = (y == Y_MAX) ? '0 : y + COORD_W'(1);
      end else begin
        x_d = x + COORD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_d;
      y <= y_d;
    end
  end

endmodule

// File: rtl/fractal_pixel_tx.sv
// Raster sweep of fractal requests with credit-limited result FIFO feeding
// the bitmap draw port. Optional frame cycle counter: FRACTAL_PIXEL_TX_STATS_EN.
module fractal_pixel_tx
  import jsv_pkg::*;
#(
  parameter int unsigned H_RES      = H_RES_DEF,
  parameter int unsigned V_RES      = V_RES_DEF,
  parameter int unsigned ITER_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               frame_start,
  output logic               calc_req,
  output logic [COORD_W-1:0] calc_x,
  output logic [COORD_W-1:0] calc_y,
  input  logic               calc_ack,
  input  logic               calc_valid,
  input  logic [ITER_W-1:0]  calc_iter,
  output logic               draw,
  output logic [COORD_W-1:0] draw_x,
  output logic [COORD_W-1:0] draw_y,
  output logic [ITER_W-1:0]  draw_i,
  input  logic               draw_ready,
  output logic               busy,
  output logic               frame_done,
  output logic               err
`ifdef FRACTAL_PIXEL_TX_STATS_EN
  ,
  output logic [31:0]        frame_cycles
`endif
);

  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CRD_W  = $clog2(FIFO_DEPTH + 2) + 1;
  localparam int unsigned SUM_W  = CRD_W + 2;

  pix_state_t         state_q;
  pix_state_t         state_d;

  logic [CRD_W-1:0]   out_cnt_q;
  logic [CRD_W-1:0]   out_cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   fifo_cnt_c;
  logic [PTR_W-1:0]   fifo_cnt_d;
  logic [ITER_W-1:0]  mem [FIFO_DEPTH];

  logic               start_c;
  logic               issue_hs_c;
  logic               draw_hs_c;
  logic               valid_ok_c;
  logic               valid_bad_c;
  logic               push_c;
  logic               pop_c;
  logic               frame_end_c;
  logic               full_d;
  logic               req_d;
  logic               fifo_empty_c;
  logic               fifo_full_c;
  logic               issue_last_c;
  logic               draw_last_c;
  logic [SUM_W-1:0]   credit_c;

  assign fifo_cnt_c   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty_c = (fifo_cnt_c == '0);
  assign fifo_full_c  = (fifo_cnt_c == PTR_W'(FIFO_DEPTH));

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_issue_cnt (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .clr    (start_c),
    .en     (issue_hs_c),
    .x      (calc_x),
    .y      (calc_y),
    .last_c (issue_last_c)
  );

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_draw_cnt (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .clr    (start_c),
    .en     (draw_hs_c),
    .x      (draw_x),
    .y      (draw_y),
    .last_c (draw_last_c)
  );

  // Next state, handshakes, FIFO control and next-cycle credit decision.
  always_comb begin
    state_d     = state_q;
    start_c     = 1'b0;
    issue_hs_c  = calc_req && calc_ack;
    draw_hs_c   = draw && draw_ready;
    valid_ok_c  = calc_valid && (out_cnt_q != '0);
    valid_bad_c = calc_valid && (out_cnt_q == '0);
    push_c      = valid_ok_c && !fifo_full_c;
    pop_c       = !fifo_empty_c && (!draw || draw_hs_c);
    frame_end_c = (state_q == DRAIN) && draw_hs_c && draw_last_c;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = ISSUE;
          start_c = 1'b1;
        end
      end
      ISSUE: begin
        if (issue_hs_c && issue_last_c) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (frame_end_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_cnt_d  = out_cnt_q + CRD_W'(issue_hs_c) - CRD_W'(valid_ok_c);
    fifo_cnt_d = fifo_cnt_c + PTR_W'(push_c) - PTR_W'(pop_c);
    full_d     = pop_c || (draw && !draw_hs_c);
    credit_c   = SUM_W'(out_cnt_d) + SUM_W'(fifo_cnt_d) + SUM_W'(full_d);
    req_d      = (state_d == ISSUE) && (credit_c < SUM_W'(FIFO_DEPTH + 1));
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      out_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      calc_req   <= 1'b0;
      draw       <= 1'b0;
      draw_i     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_cnt_q  <= out_cnt_d;
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        draw_i   <= mem[rd_ptr_q[ADDR_W-1:0]];
      end
      draw       <= full_d;
      calc_req   <= req_d;
      busy       <= (state_d != IDLE);
      frame_done <= frame_end_c;
      err        <= err || valid_bad_c;
    end
  end

  // Result storage; validity is tracked solely by the pointers.
  always_ff @(posedge clk_clk) begin
    if (push_c) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= calc_iter;
    end
  end

`ifdef FRACTAL_PIXEL_TX_STATS_EN
  logic [31:0] run_cnt_q;

  // Counts the busy cycles; the latched value includes the frame_done cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      run_cnt_q    <= '0;
      frame_cycles <= '0;
    end else begin
      if (start_c) begin
        run_cnt_q <= 32'd1;
      end else if (state_q != IDLE) begin
        run_cnt_q <= run_cnt_q + 32'd1;
      end
      if (frame_end_c) begin
        frame_cycles <= run_cnt_q + 32'd1;
      end
    end
  end
`endif

endmodule
